scsp_eg: RTL
============

// Module: scsp_eg
// PURPOSE
//  Per-slot ADSR envelope generator for the SCSP. It is time-multiplexed over 32 slots, one slot per CE.
//  It consumes slot registers SCR1, SCR2 and SCR5, plus the slot pipe (OPPipe_t: SLOT, KON, KOFF).
//  It produces a 10-bit attenuation EVOL (0 = full level, 3FF = silent) and the state ST for the output/TL stage.
//  It also produces the CR4.EG monitor value for the slot selected by MSLC.
// PARAMETERS
//  SLOTS   32  number of multiplexed slots; SLOT index width is 5
//  CNT_W   12  width of the global sample counter used for rate gating
// PORTS
//  CLK       in   1   system clock
//  RST_N     in   1   asynchronous active-low reset
//  CE        in   1   slot strobe; one slot is processed per CE
//  OP_IN     in   7   OPPipe_t {SLOT, KON, KOFF}; KON/KOFF are one-CE pulses for OP_IN.SLOT
//  SCR1      in   16  SCR1_t of OP_IN.SLOT (KRS, DL, RR, LPSLNK)
//  SCR2      in   16  SCR2_t of OP_IN.SLOT (D2R, D1R, EGHOLD, AR)
//  SCR5      in   16  SCR5_t of OP_IN.SLOT (OCT, FNS)
//  LOOP_HIT  in   1   address generator reached LSA for OP_IN.SLOT this CE
//  MSLC      in   5   CR4 monitor slot select
//  SLOT_OUT  out  5   slot index of EVOL/ST_OUT
//  EVOL      out  10  envelope attenuation, after EGHOLD
//  ST_OUT    out  2   EGState_t after the update
//  MON_EG    out  5   EVOL[9:5] of slot MSLC; updated when that slot passes
// BEHAVIOUR
//  Reset (async, RST_N=0):
//   - All slot states: EVOL=3FF, ST=RELEASE.
//   - Sample counter = 0.
//   - Outputs: SLOT_OUT=0, EVOL=3FF, ST_OUT=RELEASE, MON_EG=1F.
//   - Reset mid-sample restarts at counter 0. No partial update survives.
//  Timing:
//   - Single stage. State read, update and write-back happen on the same CE edge.
//   - Outputs are registered: valid from the CE edge that processed OP_IN.SLOT until the next CE edge.
//   - All state changes only when CE=1.
//  Sample counter:
//   - Increments (mod 2^CNT_W) on the CE where OP_IN.SLOT==31, after that slot's update.
//  Rate:
//   - RATE = RateCalc(R, KRS, SCR5); R is the 5-bit rate for the current state (AR / D1R / D2R / RR).
//   - R==0 gives no change, regardless of KRS.
//   - Let H = RATE[5:2].
//   - RATE < 30h: step when cnt[10-H:0]==0 (H=0..11), delta=1.
//   - RATE >= 30h: step every sample, delta = 1 << (H-11) (H=12..15 gives 2..16).
//  State update per slot (priority order):
//   1. KON: ST=ATTACK, EVOL=3FF. If AR==1F: EVOL=000, ST=DECAY1. KON beats KOFF in the same CE.
//   2. KOFF: ST=RELEASE; EVOL is unchanged this CE.
//   3. ATTACK, on a step: EVOL -= ((EVOL>>4)+1) << log2(delta), saturating at 0.
//      Move to DECAY1 when the result is 0.
//      If LPSLNK=1 and LOOP_HIT=1: move to DECAY1 immediately, EVOL held.
//   4. DECAY1, on a step: EVOL += delta, saturating at 3FF.
//      Move to DECAY2 when result[9:5] >= DL.
//   5. DECAY2 / RELEASE, on a step: EVOL += delta, saturating at 3FF. The state is terminal.
//  EGHOLD:
//   - While ST==ATTACK and EGHOLD=1, the EVOL output is 000.
//   - The internal EVOL keeps attacking.
//  Arithmetic:
//   - All math is unsigned, 11-bit intermediate, clamped to [000, 3FF]. Wrap-around is never allowed.
//  Slot order:
//   - OP_IN.SLOT is not required to be sequential.
//   - The counter increments only on slot 31.
// STRUCTURE
//  Package additions to SCSP_PKG:
//   - EGSlot_t {EVOL, ST} (= OP4State_t)
//   - EG_EVOL_MAX = 10'h3FF
//   - function EGDelta(RATE, cnt) -> {step, delta}
//  Reused: RateCalc, EGState_t.
//  State storage: a 32 x 12 flop array (async reset required, so no BRAM).
//  One sub-module: scsp_eg_rate (combinational RateCalc, gating and delta).
// TESTING
//  1. Reset, then KON slot 5 with AR=1F -> next CE EVOL=000, ST_OUT=DECAY1, SLOT_OUT=5.
//  2. KON slot 0 with AR=0A, KRS=F, then run full samples -> EVOL strictly decreases, reaches 000, ST=DECAY1; never below 0.
//  3. DECAY1 with D1R=1F, DL=04 -> ST switches to DECAY2 on the first CE with EVOL[9:5]>=04.
//     D2R=1F then saturates at 3FF with no wrap.
//  4. KON and KOFF on the same CE for slot 3 -> ST_OUT=ATTACK.
//     KOFF alone on the next sample -> RELEASE, EVOL unchanged that CE.
//  5. EGHOLD=1 during attack -> EVOL output 000 while the internal value (seen via MON_EG with MSLC=slot) still decreases.
//  6. Assert RST_N low mid-sample at slot 17 -> all outputs at reset values immediately.
//     After release, the slot 17 state is 3FF/RELEASE.

Source files
------------

// File: rtl/scsp_eg_pkg.sv
// Shared types and helpers for the SCSP envelope generator: register layouts,
// per-slot envelope state, and the rate/step arithmetic.
package scsp_eg_pkg;

    localparam int SLOTS  = 32;
    localparam int SLOT_W = 5;
    localparam int CNT_W  = 12;
    localparam logic [9:0] EG_EVOL_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY1  = 2'd1,
        DECAY2  = 2'd2,
        RELEASE = 2'd3
    } EGState_t;

    typedef struct packed {
        logic [SLOT_W-1:0] SLOT;
        logic              KON;
        logic              KOFF;
    } OPPipe_t;

    typedef struct packed {
        logic       rsv;
        logic       LPSLNK;
        logic [3:0] KRS;
        logic [4:0] DL;
        logic [4:0] RR;
    } SCR1_t;

    typedef struct packed {
        logic [4:0] D2R;
        logic [4:0] D1R;
        logic       EGHOLD;
        logic [4:0] AR;
    } SCR2_t;

    typedef struct packed {
        logic       rsv0;
        logic [3:0] OCT;
        logic       rsv1;
        logic [9:0] FNS;
    } SCR5_t;

    typedef struct packed {
        logic [9:0] EVOL;
        EGState_t   ST;
    } EGSlot_t;

    typedef struct packed {
        logic       step;
        logic [4:0] delta;
        logic [2:0] shft;
    } EGDelta_t;

    // Effective rate 0..63: 2*R plus key-rate scaling (skipped when KRS=F); OCT is signed.
    function automatic logic [5:0] RateCalc(input logic [4:0] r, input logic [3:0] krs,
                                            input logic [3:0] oct, input logic fns9);
        logic signed [7:0] rate;
        logic [5:0]        res;
        rate = $signed({2'b00, r, 1'b0});
        if (krs != 4'hF)
            rate = rate + $signed({3'b000, krs, 1'b0}) + $signed({{3{oct[3]}}, oct, 1'b0})
                        + $signed({7'd0, fns9});
        if (r == 5'd0 || rate < 8'sd0) res = 6'd0;
        else if (rate > 8'sd63)        res = 6'd63;
        else                           res = rate[5:0];
        return res;
    endfunction

    function automatic EGDelta_t EGDelta(input logic [5:0] rate, input logic [CNT_W-1:0] cnt);
        EGDelta_t         d;
        logic [3:0]       h;
        logic [CNT_W-1:0] mask;
        h    = rate[5:2];
        d    = '0;
        mask = {{(CNT_W-11){1'b0}}, 11'h7FF} >> h;
        if (rate < 6'h30) begin
            d.step  = (cnt & mask) == '0;
            d.delta = 5'd1;
            d.shft  = 3'd0;
        end else begin
            d.step  = 1'b1;
            d.shft  = 3'(h - 4'd11);
            d.delta = 5'd1 << d.shft;
        end
        return d;
    endfunction

endpackage

// File: rtl/scsp_eg_rate.sv
// Selects the rate for the slot's current state and turns it into a step
// strobe plus increment (and its log2) for this sample.
module scsp_eg_rate import scsp_eg_pkg::*; (
    input  EGState_t         st_i,
    input  logic [4:0]       ar_i,
    input  logic [4:0]       d1r_i,
    input  logic [4:0]       d2r_i,
    input  logic [4:0]       rr_i,
    input  logic [3:0]       krs_i,
    input  logic [3:0]       oct_i,
    input  logic             fns9_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             step_o,
    output logic [4:0]       delta_o,
    output logic [2:0]       shft_o
);
    logic [4:0] r;
    logic [5:0] rate;
    EGDelta_t   d;

    always_comb begin
        case (st_i)
            ATTACK:  r = ar_i;
            DECAY1:  r = d1r_i;
            DECAY2:  r = d2r_i;
            default: r = rr_i;
        endcase
    end

    assign rate = RateCalc(r, krs_i, oct_i, fns9_i);
    assign d    = EGDelta(rate, cnt_i);

    // A zero rate freezes the envelope even if key scaling lifts RATE.
    assign step_o  = d.step & (r != 5'd0);
    assign delta_o = d.delta;
    assign shft_o  = d.shft;

endmodule

// File: rtl/scsp_eg.sv
// Time-multiplexed ADSR envelope generator: one slot read, updated and written
// back per CE, with registered EVOL/ST outputs and a CR4 monitor tap.
module scsp_eg import scsp_eg_pkg::*; (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE,
    input  logic [6:0]  OP_IN,
    input  logic [15:0] SCR1,
    input  logic [15:0] SCR2,
    input  logic [15:0] SCR5,
    input  logic        LOOP_HIT,
    input  logic [4:0]  MSLC,
    output logic [4:0]  SLOT_OUT,
    output logic [9:0]  EVOL,
    output logic [1:0]  ST_OUT,
    output logic [4:0]  MON_EG
);
    OPPipe_t op;
    SCR1_t   s1;
    SCR2_t   s2;
    SCR5_t   s5;

    assign op = OPPipe_t'(OP_IN);
    assign s1 = SCR1_t'(SCR1);
    assign s2 = SCR2_t'(SCR2);
    assign s5 = SCR5_t'(SCR5);

    EGSlot_t          slot_q [SLOTS];
    EGSlot_t          cur, slot_d;
    logic [CNT_W-1:0] cnt_q;
    logic [4:0]       slot_out_q, mon_q;
    logic [9:0]       evol_q, evol_d;
    EGState_t         st_q;

    logic       step;
    logic [4:0] delta;
    logic [2:0] shft;
    logic [10:0] inc_w, dec_w;
    logic [9:0]  evol_inc, evol_dec;

    assign cur = slot_q[op.SLOT];

    scsp_eg_rate u_rate (
        .st_i    (cur.ST),
        .ar_i    (s2.AR),
        .d1r_i   (s2.D1R),
        .d2r_i   (s2.D2R),
        .rr_i    (s1.RR),
        .krs_i   (s1.KRS),
        .oct_i   (s5.OCT),
        .fns9_i  (s5.FNS[9]),
        .cnt_i   (cnt_q),
        .step_o  (step),
        .delta_o (delta),
        .shft_o  (shft)
    );

    always_comb begin
        // 11-bit intermediates so neither direction can wrap before clamping.
        inc_w    = {1'b0, cur.EVOL} + {6'd0, delta};
        dec_w    = {4'd0, {1'b0, cur.EVOL[9:4]} + 7'd1} << shft;
        evol_inc = (inc_w > 11'h3FF) ? EG_EVOL_MAX : inc_w[9:0];
        evol_dec = (dec_w >= {1'b0, cur.EVOL}) ? 10'd0 : cur.EVOL - dec_w[9:0];

        slot_d = cur;
        if (op.KON) begin
            slot_d.ST   = ATTACK;
            slot_d.EVOL = EG_EVOL_MAX;
            if (s2.AR == 5'h1F) begin
                slot_d.ST   = DECAY1;
                slot_d.EVOL = '0;
            end
        end else if (op.KOFF) begin
            slot_d.ST = RELEASE;
        end else begin
            case (cur.ST)
                ATTACK: begin
                    if (s1.LPSLNK && LOOP_HIT) begin
                        slot_d.ST = DECAY1;
                    end else if (step) begin
                        slot_d.EVOL = evol_dec;
                        if (evol_dec == '0) slot_d.ST = DECAY1;
                    end
                end
                DECAY1: begin
                    if (step) begin
                        slot_d.EVOL = evol_inc;
                        if (evol_inc[9:5] >= s1.DL) slot_d.ST = DECAY2;
                    end
                end
                default: if (step) slot_d.EVOL = evol_inc;
            endcase
        end

        evol_d = (slot_d.ST == ATTACK && s2.EGHOLD) ? 10'd0 : slot_d.EVOL;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < SLOTS; i++) slot_q[i] <= '{EVOL: EG_EVOL_MAX, ST: RELEASE};
            cnt_q      <= '0;
            slot_out_q <= '0;
            evol_q     <= EG_EVOL_MAX;
            st_q       <= RELEASE;
            mon_q      <= 5'h1F;
        end else if (CE) begin
            slot_q[op.SLOT] <= slot_d;
            if (op.SLOT == 5'(SLOTS - 1)) cnt_q <= cnt_q + CNT_W'(1);
            slot_out_q <= op.SLOT;
            evol_q     <= evol_d;
            st_q       <= slot_d.ST;
            if (op.SLOT == MSLC) mon_q <= slot_d.EVOL[9:5];
        end
    end

    assign SLOT_OUT = slot_out_q;
    assign EVOL     = evol_q;
    assign ST_OUT   = st_q;
    assign MON_EG   = mon_q;

    logic unused_ok;
    assign unused_ok = ^{s1.rsv, s5.rsv0, s5.rsv1, s5.FNS[8:0]};

endmodule
